// File: rtl/load_store_unit.sv
// RV32I load/store stage in front of a word-wide synchronous RAM without byte enables.
// Sub-word stores read the old word, merge the new lane and write it back.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  req_error,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    write_reg;
  logic [2:0]              funct3_reg;
  logic [1:0]              offset_reg;
  logic [15:0]             wdata_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             resp_rdata_reg;

  logic                    bad_funct3, misaligned, bad_store, req_bad;
  logic                    is_sw, accept_multi;
  logic [ADDR_WIDTH-1:0]   req_word;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_data;
  logic [31:0]             merged;
  logic                    unused_addr_bits;

  // Upper address bits are deliberately dropped: the RAM address wraps.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];
  assign req_word         = req_addr[ADDR_WIDTH+1:2];

  assign bad_funct3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111);
  assign misaligned = ((req_funct3 == F_H || req_funct3 == F_HU) && req_addr[0]) ||
                      ((req_funct3 == F_W) && (req_addr[1:0] != 2'b00));
  assign bad_store  = req_write && req_funct3[2];
  assign req_bad    = bad_funct3 || misaligned || bad_store;
  assign is_sw      = req_write && (req_funct3 == F_W);

  // Requests that occupy more than one cycle latch their operands.
  assign accept_multi = (state_reg == IDLE) && req_valid && !req_bad && !is_sw;

  // Load lane extraction from the word returned in RD_WAIT.
  always_comb begin
    byte_sel = mem_rdata[{offset_reg, 3'b000} +: 8];
    half_sel = offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      F_B:     load_data = {{24{byte_sel[7]}}, byte_sel};
      F_BU:    load_data = {24'd0, byte_sel};
      F_H:     load_data = {{16{half_sel[15]}}, half_sel};
      F_HU:    load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Store merge: each byte lane either keeps the old RAM byte or takes new data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = (funct3_reg[1:0] == 2'b00) ? (offset_reg == 2'(gi))
                                                   : (offset_reg[1] == 1'(gi / 2));
      assign merged[8*gi +: 8] = !lane_hit ? mem_rdata[8*gi +: 8] :
                                 (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0]
                                                            : wdata_reg[8*(gi % 2) +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    resp_valid = 1'b0;
    req_error  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = req_word;
    mem_wdata  = 32'd0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              req_error = 1'b1;
            end else if (is_sw) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_wdata = req_wdata;
            end else begin
              mem_en     = 1'b1;
              stall      = 1'b1;
              state_next = req_write ? RMW : RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          stall      = 1'b1;
          mem_addr   = addr_reg;
          state_next = DONE;
        end
        RMW: begin
          stall      = 1'b1;
          mem_en     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = addr_reg;
          mem_wdata  = merged;
          state_next = DONE;
        end
        DONE: begin
          // The requester still holds the finished op here, so req_valid is ignored.
          resp_valid = !write_reg;
          mem_addr   = addr_reg;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      funct3_reg     <= 3'd0;
      offset_reg     <= 2'd0;
      wdata_reg      <= 16'd0;
      addr_reg       <= '0;
      resp_rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept_multi) begin
        write_reg  <= req_write;
        funct3_reg <= req_funct3;
        offset_reg <= req_addr[1:0];
        wdata_reg  <= req_wdata[15:0];
        addr_reg   <= req_word;
      end
      if (state_reg == RD_WAIT) begin
        resp_rdata_reg <= load_data;
      end
    end
  end

  assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit with a behavioural word RAM.
module tb_load_store_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          stall, resp_valid, req_error, mem_en, mem_we;
  logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          bd_en;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .req_error(req_error), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expected load result.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected got %h expected no response", resp_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e);
        $display("resp data %h expected %h", resp_rdata, e);
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [31:0] sh, v;
    sh = w >> (8 * off);
    case (f3)
      3'b000: begin v = sh & 32'hFF;   return (v >= 128)   ? v + 32'hFFFFFF00 : v; end
      3'b100: return sh & 32'hFF;
      3'b001: begin v = sh & 32'hFFFF; return (v >= 32768) ? v + 32'hFFFF0000 : v; end
      3'b101: return sh & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    mask = (f3 == 3'b000) ? 32'hFF : (f3 == 3'b001) ? 32'hFFFF : 32'hFFFFFFFF;
    return (old & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
  endfunction

  function automatic logic ref_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (w && f3[2]) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one request (entered at posedge+1) and returns at posedge+1 after it is consumed.
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    logic err, ld;
    int   n, exp_stall;
    err = ref_err(w, f3, a);
    ld  = !err && !w;
    exp_stall = (err || (w && f3 == 3'b010)) ? 0 : 2;
    if (ld) exp_q.push_back(ref_load(f3, ref_mem[a[5:2]], a[1:0]));
    else if (!err) ref_mem[a[5:2]] = ref_store(f3, ref_mem[a[5:2]], a[1:0], d);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    $display("op write=%0d funct3=%0d addr=%h data=%h error_expected=%0d", w, f3, a, d, err);
    @(negedge clk);
    chk("req_error", req_error, err);
    chk("mem_en", mem_en, !err);
    if (!err) chk("mem_addr", mem_addr, a[13:2]);
    n = 0;
    while (stall === 1'b1 && n < 8) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, exp_stall);
    chk("resp_valid", resp_valid, ld);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_mem_en", mem_en, 1'b0);
    chk("idle_stall", stall, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        w;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011;
    req_addr = 32'h40; req_wdata = 32'd0; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = (i == 0) ? 32'h8899AABB : $urandom;
      bd_en = 1'b1; bd_addr = AW'(16 + i); bd_data = ref_mem[i];
      @(posedge clk); #1;
    end
    bd_en = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_req_error", req_error, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle();

    // Directed: sign/zero extension on a known word.
    do_op(1'b0, 3'b000, 32'h43, 32'd0);
    do_op(1'b0, 3'b100, 32'h43, 32'd0);
    do_op(1'b0, 3'b101, 32'h42, 32'd0);
    // Single-cycle store followed immediately by a load of the same word.
    do_op(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    chk("sw_ram", ram[16], 32'hDEADBEEF);
    do_op(1'b0, 3'b010, 32'h40, 32'd0);
    // Read-modify-write stores.
    do_op(1'b1, 3'b010, 32'h40, 32'h11223344);
    do_op(1'b1, 3'b000, 32'h41, 32'hFFFFFFAA);
    chk("sb_ram", ram[16], 32'h1122AA44);
    do_op(1'b1, 3'b001, 32'h42, 32'h00005555);
    chk("sh_ram", ram[16], 32'h5555AA44);
    // Illegal requests are dropped.
    do_op(1'b0, 3'b010, 32'h42, 32'd0);
    do_op(1'b1, 3'b001, 32'h43, 32'h1234);
    do_op(1'b0, 3'b011, 32'h40, 32'd0);
    do_op(1'b1, 3'b100, 32'h40, 32'h99);
    chk("err_ram", ram[16], 32'h5555AA44);
    // Address wrap beyond the RAM word-address width.
    do_op(1'b0, 3'b010, 32'h00004040, 32'd0);

    // Reset during the write-back cycle of a byte store aborts it.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h40; req_wdata = 32'h77;
    @(negedge clk);
    chk("abort_stall_t", stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_after_stall", stall, 1'b0);
    chk("abort_after_resp_rdata", resp_rdata, 32'd0);
    chk("abort_ram", ram[16], 32'h5555AA44);
    @(posedge clk); #1;

    // Randomised traffic over sixteen words with random wrapped upper address bits.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFFC000) | 32'h40 | ($urandom & 32'h3F);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (w) f3[2] = 1'b0;
      end
      do_op(w, f3, a, $urandom);
    end
    idle_cycle();
    idle_cycle();
    chk("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) chk("final_ram", ram[16 + i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
